// File: rtl/jtcps1_vram_arb.sv
// jtcps1_vram_arb: shares the VRAM SDRAM port between CPU accesses and the
// video DMA. CPU reads go straight through; a DMA bus request waits for any
// in-flight CPU access to drain before busack is raised.
// Optional feature: define JTCPS1_VRAM_ARB_WDOG_EN to enable a watchdog that
// aborts an unanswered SDRAM read after TOUT cycles, returns 16'hFFFF and
// raises the sticky arb_err flag.
module jtcps1_vram_arb #(
    parameter int TOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    // CPU side
    input  logic        cpu_cs,
    input  logic [17:1] cpu_addr,
    output logic        cpu_ok,
    output logic [15:0] cpu_din,
    // video DMA side
    input  logic        busreq,
    output logic        busack,
    input  logic [17:1] dma_addr,
    input  logic        dma_cs,
    input  logic        dma_clr,
    output logic        dma_ok,
    output logic [15:0] dma_data,
    input  logic        rfsh_en_in,
    // SDRAM controller side
    output logic [16:0] ram_addr,
    output logic        ram_cs,
    input  logic        ram_ok,
    input  logic [15:0] ram_data,
    output logic        rfsh_en,
    output logic        arb_err
);

    if (TOUT < 1) begin : g_bad_tout
        $error("jtcps1_vram_arb: TOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CPU   = 2'd1,
        ST_WAITG = 2'd2,
        ST_DMA   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_busack;
    logic [15:0] r_cpu_din;
    logic        w_ram_cs;
    logic        w_ack;
    logic        w_tout;
    logic        w_cpu_ok;
    logic        w_dma_ok;
    logic        w_rfsh;
    logic [15:0] w_rdata;

    // The CPU owns the SDRAM port while in CPU or WAITG; in DMA the DMA strobe
    // passes through unless the DMA is aborting its read this cycle.
    assign w_ram_cs = (r_state == ST_CPU) || (r_state == ST_WAITG) ||
                      ((r_state == ST_DMA) && dma_cs && !dma_clr);
    // ram_ok only counts when a request is actually outstanding.
    assign w_ack    = w_ram_cs && ram_ok;
    // A watchdog abort substitutes all-ones for the missing data.
    assign w_rdata  = w_tout ? 16'hFFFF : ram_data;

`ifdef JTCPS1_VRAM_ARB_WDOG_EN
    localparam int CW = $clog2(TOUT + 1);

    logic [CW-1:0] r_wdog;
    logic          r_err;

    assign w_tout  = w_ram_cs && !ram_ok && (r_wdog == CW'(TOUT - 1));
    assign arb_err = r_err;

    // Count cycles spent waiting on the SDRAM; restart on any answer, idle
    // port or state change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wdog <= '0;
        end else if (w_ack || !w_ram_cs || (w_next != r_state)) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + CW'(1);
        end
    end

    // Sticky error flag: once a timeout happens only reset clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (w_tout) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_tout  = 1'b0;
    assign arb_err = 1'b0;
`endif

    // State register; reset drops any access in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        w_next   = r_state;
        w_cpu_ok = 1'b0;
        w_dma_ok = 1'b0;
        w_rfsh   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rfsh = 1'b1;
                if (busreq) begin
                    w_next = ST_DMA;
                end else if (cpu_cs) begin
                    w_next = ST_CPU;
                end
            end
            ST_CPU: begin
                if (w_ack || w_tout) begin
                    w_cpu_ok = 1'b1;
                    w_next   = ST_IDLE;
                end else if (busreq) begin
                    w_next = ST_WAITG;
                end
            end
            ST_WAITG: begin
                if (w_ack || w_tout) begin
                    w_cpu_ok = 1'b1;
                    w_next   = (busreq && !w_tout) ? ST_DMA : ST_IDLE;
                end
            end
            ST_DMA: begin
                w_rfsh = rfsh_en_in;
                if (w_tout) begin
                    w_dma_ok = 1'b1;
                    w_next   = ST_IDLE;
                end else begin
                    w_dma_ok = w_ack;
                    // Stay until the DMA lets go and no read is left unanswered.
                    if (!busreq && !(w_ram_cs && !ram_ok)) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // busack follows one cycle behind a DMA grant and drops one cycle after
    // busreq falls or the grant is lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busack <= 1'b0;
        end else begin
            r_busack <= (r_state == ST_DMA) && (w_next == ST_DMA) && busreq;
        end
    end

    // Hold the last CPU read word so cpu_din stays stable after cpu_ok.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cpu_din <= 16'h0000;
        end else if (w_cpu_ok) begin
            r_cpu_din <= w_rdata;
        end
    end

    assign ram_cs   = w_ram_cs;
    assign ram_addr = (r_state == ST_DMA) ? dma_addr : cpu_addr;
    assign cpu_ok   = w_cpu_ok;
    assign cpu_din  = w_cpu_ok ? w_rdata : r_cpu_din;
    assign dma_ok   = w_dma_ok;
    assign dma_data = w_rdata;
    assign busack   = r_busack;
    assign rfsh_en  = w_rfsh;

endmodule

// File: tb/tb_jtcps1_vram_arb.sv
// tb_jtcps1_vram_arb: directed-vector bench for jtcps1_vram_arb.
// Inputs change 1 time unit after the rising edge; outputs are read 1 unit
// later, well away from the next edge. Cycle 0 of each scenario is the cycle
// in which the first request is presented while the arbiter sits in IDLE.
module tb_jtcps1_vram_arb;

    logic        clk;
    logic        rstn;
    logic        cpu_cs;
    logic [17:1] cpu_addr;
    logic        cpu_ok;
    logic [15:0] cpu_din;
    logic        busreq;
    logic        busack;
    logic [17:1] dma_addr;
    logic        dma_cs;
    logic        dma_clr;
    logic        dma_ok;
    logic [15:0] dma_data;
    logic        rfsh_en_in;
    logic [16:0] ram_addr;
    logic        ram_cs;
    logic        ram_ok;
    logic [15:0] ram_data;
    logic        rfsh_en;
    logic        arb_err;

    int errors = 0;
    int checks = 0;

    jtcps1_vram_arb #(.TOUT(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cpu_cs     (cpu_cs),
        .cpu_addr   (cpu_addr),
        .cpu_ok     (cpu_ok),
        .cpu_din    (cpu_din),
        .busreq     (busreq),
        .busack     (busack),
        .dma_addr   (dma_addr),
        .dma_cs     (dma_cs),
        .dma_clr    (dma_clr),
        .dma_ok     (dma_ok),
        .dma_data   (dma_data),
        .rfsh_en_in (rfsh_en_in),
        .ram_addr   (ram_addr),
        .ram_cs     (ram_cs),
        .ram_ok     (ram_ok),
        .ram_data   (ram_data),
        .rfsh_en    (rfsh_en),
        .arb_err    (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_cs     = 1'b0;
        cpu_addr   = '0;
        busreq     = 1'b0;
        dma_addr   = '0;
        dma_cs     = 1'b0;
        dma_clr    = 1'b0;
        rfsh_en_in = 1'b0;
        ram_ok     = 1'b0;
        ram_data   = 16'h0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        #2;
        checks++; if (busack !== 1'b0) begin errors++; $display("FAIL reset_busack: got %b want 0", busack); end
        checks++; if (cpu_ok !== 1'b0) begin errors++; $display("FAIL reset_cpu_ok: got %b want 0", cpu_ok); end
        checks++; if (dma_ok !== 1'b0) begin errors++; $display("FAIL reset_dma_ok: got %b want 0", dma_ok); end
        checks++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL reset_ram_cs: got %b want 0", ram_cs); end
        checks++; if (cpu_din !== 16'h0000) begin errors++; $display("FAIL reset_cpu_din: got %h want 0000", cpu_din); end
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL reset_arb_err: got %b want 0", arb_err); end
        checks++; if (rfsh_en !== 1'b1) begin errors++; $display("FAIL reset_rfsh_en: got %b want 1", rfsh_en); end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // CPU read answered in cycle 5
    task automatic test_cpu_read();
        int pulses;
        pulses = 0;
        tick();
        cpu_cs = 1'b1; cpu_addr = 17'h00100;
        #1;
        checks++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL cpu_rd_idle_cs c0: got %b want 0", ram_cs); end
        for (int c = 1; c <= 5; c++) begin
            tick();
            ram_ok   = (c == 5);
            ram_data = (c == 5) ? 16'h1234 : 16'h0000;
            #1;
            if (cpu_ok === 1'b1) pulses++;
            checks++; if (ram_cs !== 1'b1 || ram_addr !== 17'h00100 || busack !== 1'b0)
                begin errors++; $display("FAIL cpu_rd_bus c%0d: got cs=%b addr=%h ack=%b want cs=1 addr=00100 ack=0", c, ram_cs, ram_addr, busack); end
            checks++; if (cpu_ok !== (c == 5)) begin errors++; $display("FAIL cpu_rd_ok c%0d: got %b want %b", c, cpu_ok, (c == 5)); end
        end
        checks++; if (cpu_din !== 16'h1234) begin errors++; $display("FAIL cpu_rd_din: got %h want 1234", cpu_din); end
        for (int c = 6; c <= 8; c++) begin
            tick();
            cpu_cs = 1'b0; ram_ok = 1'b0; ram_data = 16'h0000;
            #1;
            if (cpu_ok === 1'b1) pulses++;
            checks++; if (ram_cs !== 1'b0 || busack !== 1'b0 || rfsh_en !== 1'b1)
                begin errors++; $display("FAIL cpu_rd_after c%0d: got cs=%b ack=%b rfsh=%b want 0 0 1", c, ram_cs, busack, rfsh_en); end
        end
        checks++; if (cpu_din !== 16'h1234) begin errors++; $display("FAIL cpu_rd_hold: got %h want 1234", cpu_din); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL cpu_rd_pulses: got %0d want 1", pulses); end
    endtask

    // busreq rises in cycle 2 of a CPU access answered in cycle 6
    task automatic test_busreq_during_cpu();
        tick();
        cpu_cs = 1'b1; cpu_addr = 17'h00200;
        #1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 2) busreq = 1'b1;
            if (c == 11) busreq = 1'b0;
            ram_ok   = (c == 6);
            ram_data = (c == 6) ? 16'hBEEF : 16'h0000;
            if (c == 7) cpu_cs = 1'b0;
            rfsh_en_in = (c == 9);
            #1;
            checks++; if (busack !== (c >= 8 && c <= 11)) begin errors++; $display("FAIL grant_busack c%0d: got %b want %b", c, busack, (c >= 8 && c <= 11)); end
            checks++; if (cpu_ok !== (c == 6)) begin errors++; $display("FAIL grant_cpu_ok c%0d: got %b want %b", c, cpu_ok, (c == 6)); end
            if (c == 4) begin
                checks++; if (rfsh_en !== 1'b0 || ram_cs !== 1'b1) begin errors++; $display("FAIL grant_waitg c4: got rfsh=%b cs=%b want 0 1", rfsh_en, ram_cs); end
            end
            if (c == 6) begin
                checks++; if (cpu_din !== 16'hBEEF) begin errors++; $display("FAIL grant_cpu_din: got %h want beef", cpu_din); end
            end
            if (c == 8 || c == 9) begin
                checks++; if (rfsh_en !== rfsh_en_in) begin errors++; $display("FAIL grant_rfsh c%0d: got %b want %b", c, rfsh_en, rfsh_en_in); end
            end
            if (c == 12) begin
                checks++; if (rfsh_en !== 1'b1) begin errors++; $display("FAIL grant_release_idle: got rfsh=%b want 1", rfsh_en); end
            end
        end
        idle_inputs();
        tick();
    endtask

    // DMA reads: normal, stray ram_ok, dma_clr abort, release with one read pending
    task automatic test_dma_read();
        tick();
        busreq = 1'b1;
        #1;
        tick(); #1;
        checks++; if (busack !== 1'b0) begin errors++; $display("FAIL dma_busack_early: got %b want 0", busack); end
        tick();
        dma_cs = 1'b1; dma_addr = 17'h1ABCD;
        #1;
        checks++; if (busack !== 1'b1 || ram_cs !== 1'b1 || ram_addr !== 17'h1ABCD)
            begin errors++; $display("FAIL dma_pass: got ack=%b cs=%b addr=%h want 1 1 1abcd", busack, ram_cs, ram_addr); end
        tick();
        ram_ok = 1'b1; ram_data = 16'h5A5A;
        #1;
        checks++; if (dma_ok !== 1'b1 || dma_data !== 16'h5A5A) begin errors++; $display("FAIL dma_data: got ok=%b data=%h want 1 5a5a", dma_ok, dma_data); end
        tick();
        dma_cs = 1'b0; ram_ok = 1'b1; ram_data = 16'h1111;
        #1;
        checks++; if (dma_ok !== 1'b0 || ram_cs !== 1'b0) begin errors++; $display("FAIL dma_stray_ok: got ok=%b cs=%b want 0 0", dma_ok, ram_cs); end
        tick();
        ram_ok = 1'b0; dma_cs = 1'b1; dma_addr = 17'h00042;
        #1;
        tick();
        dma_clr = 1'b1; ram_ok = 1'b1; ram_data = 16'h2222;
        #1;
        checks++; if (dma_ok !== 1'b0 || ram_cs !== 1'b0) begin errors++; $display("FAIL dma_clr: got ok=%b cs=%b want 0 0", dma_ok, ram_cs); end
        tick();
        dma_clr = 1'b0; ram_ok = 1'b0; busreq = 1'b0;
        #1;
        checks++; if (busack !== 1'b1 || ram_cs !== 1'b1) begin errors++; $display("FAIL dma_rel_c7: got ack=%b cs=%b want 1 1", busack, ram_cs); end
        tick();
        ram_ok = 1'b1; ram_data = 16'h3333;
        #1;
        checks++; if (busack !== 1'b0 || ram_cs !== 1'b1 || dma_ok !== 1'b1 || rfsh_en !== 1'b0)
            begin errors++; $display("FAIL dma_rel_pending: got ack=%b cs=%b ok=%b rfsh=%b want 0 1 1 0", busack, ram_cs, dma_ok, rfsh_en); end
        tick();
        dma_cs = 1'b0; ram_ok = 1'b0;
        #1;
        checks++; if (rfsh_en !== 1'b1 || ram_cs !== 1'b0) begin errors++; $display("FAIL dma_back_idle: got rfsh=%b cs=%b want 1 0", rfsh_en, ram_cs); end
        idle_inputs();
    endtask

    // busreq and cpu_cs together: DMA first, CPU afterwards
    task automatic test_simultaneous();
        int early;
        early = 0;
        tick();
        busreq = 1'b1; cpu_cs = 1'b1; cpu_addr = 17'h00300;
        #1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            dma_cs   = (c == 2 || c == 3);
            dma_addr = 17'h00400;
            if (c == 3) busreq = 1'b0;
            ram_ok   = (c == 3 || c == 6);
            ram_data = (c == 3) ? 16'h7777 : 16'h4321;
            #1;
            if (c <= 5 && cpu_ok !== 1'b0) early++;
            if (c == 2) begin
                checks++; if (busack !== 1'b1 || ram_addr !== 17'h00400) begin errors++; $display("FAIL both_dma_first: got ack=%b addr=%h want 1 00400", busack, ram_addr); end
            end
            if (c == 3) begin
                checks++; if (dma_ok !== 1'b1 || dma_data !== 16'h7777) begin errors++; $display("FAIL both_dma_ok: got ok=%b data=%h want 1 7777", dma_ok, dma_data); end
            end
            if (c == 5) begin
                checks++; if (busack !== 1'b0 || ram_cs !== 1'b1 || ram_addr !== 17'h00300)
                    begin errors++; $display("FAIL both_cpu_go: got ack=%b cs=%b addr=%h want 0 1 00300", busack, ram_cs, ram_addr); end
            end
            if (c == 6) begin
                checks++; if (cpu_ok !== 1'b1 || cpu_din !== 16'h4321) begin errors++; $display("FAIL both_cpu_ok: got ok=%b din=%h want 1 4321", cpu_ok, cpu_din); end
            end
        end
        checks++; if (early != 0) begin errors++; $display("FAIL both_cpu_early: got %0d early pulses want 0", early); end
        tick();
        idle_inputs();
        tick();
    endtask

    // Asynchronous reset in the middle of a DMA read
    task automatic test_reset_mid_dma();
        int stray;
        stray = 0;
        tick();
        busreq = 1'b1;
        #1;
        tick(); #1;
        tick();
        dma_cs = 1'b1; dma_addr = 17'h00055;
        #1;
        checks++; if (busack !== 1'b1 || rfsh_en !== 1'b0) begin errors++; $display("FAIL rst_dma_pre: got ack=%b rfsh=%b want 1 0", busack, rfsh_en); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (busack !== 1'b0 || rfsh_en !== 1'b1 || ram_cs !== 1'b0)
            begin errors++; $display("FAIL rst_dma_now: got ack=%b rfsh=%b cs=%b want 0 1 0", busack, rfsh_en, ram_cs); end
        busreq = 1'b0; dma_cs = 1'b0;
        tick();
        ram_ok = 1'b1; ram_data = 16'h9999;
        rstn = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) ram_ok = 1'b0;
            #1;
            if (cpu_ok !== 1'b0 || dma_ok !== 1'b0 || busack !== 1'b0 || ram_cs !== 1'b0) stray++;
            tick();
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_dma_stray: got %0d bad cycles want 0", stray); end
        idle_inputs();
    endtask

    task automatic test_watchdog();
        tick();
        cpu_cs = 1'b1; cpu_addr = 17'h00600;
        #1;
`ifdef JTCPS1_VRAM_ARB_WDOG_EN
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 17) cpu_cs = 1'b0;
            #1;
            checks++; if (cpu_ok !== (c == 16)) begin errors++; $display("FAIL wdog_ok c%0d: got %b want %b", c, cpu_ok, (c == 16)); end
            if (c == 16) begin
                checks++; if (cpu_din !== 16'hFFFF) begin errors++; $display("FAIL wdog_din: got %h want ffff", cpu_din); end
            end
            checks++; if (arb_err !== (c >= 17)) begin errors++; $display("FAIL wdog_err c%0d: got %b want %b", c, arb_err, (c >= 17)); end
        end
`else
        for (int c = 1; c <= 40; c++) begin
            tick();
            #1;
            if (c == 40) begin
                checks++; if (cpu_ok !== 1'b0 || ram_cs !== 1'b1 || arb_err !== 1'b0)
                    begin errors++; $display("FAIL nowdog_wait: got ok=%b cs=%b err=%b want 0 1 0", cpu_ok, ram_cs, arb_err); end
            end
        end
        cpu_cs = 1'b0;
`endif
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (arb_err !== 1'b0 || ram_cs !== 1'b0) begin errors++; $display("FAIL wdog_reset: got err=%b cs=%b want 0 0", arb_err, ram_cs); end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_busreq_during_cpu();
        test_dma_read();
        test_simultaneous();
        test_reset_mid_dma();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
